// File: rtl/harmonic_pkg.sv
// Shared types and constants for the harmonic partial-sum engine.
package harmonic_pkg;

    localparam logic MODE_HARM = 1'b0;
    localparam logic MODE_ALT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Elaboration-time reciprocal: floor(2^frac_w / k); recip(1) is exactly 2^frac_w.
    function automatic logic [63:0] recip(input int unsigned k, input int unsigned frac_w);
        return (64'd1 << frac_w) / 64'(k);
    endfunction

endpackage

// File: rtl/harmonic_recip_rom.sv
// Synchronous-read reciprocal table; entry a holds recip(a+1). Output is registered, no reset.
module harmonic_recip_rom #(
    parameter int N_MAX  = 32,
    parameter int FRAC_W = 16,
    parameter int AW     = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
    input  logic              i_clk,
    input  logic [AW-1:0]     i_addr,
    output logic [FRAC_W:0]   o_data
);
    import harmonic_pkg::*;

    localparam int RW    = FRAC_W + 1;
    localparam int DEPTH = 2 ** AW;

    logic [FRAC_W:0] w_tab [DEPTH];

    // Rows beyond N_MAX are never addressed; tie them off so the table is fully defined.
    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        if (g < N_MAX) begin : g_used
            assign w_tab[g] = RW'(recip(g + 1, FRAC_W));
        end else begin : g_pad
            assign w_tab[g] = '0;
        end
    end

    logic [FRAC_W:0] r_data;

    always_ff @(posedge i_clk) begin
        r_data <= w_tab[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/harmonic_series_engine.sv
// Fixed-point partial-sum engine: S(n) = sum of s_k/k, harmonic or alternating sign,
// with start/busy/done handshake and a registered reciprocal ROM.
module harmonic_series_engine #(
    parameter int N_MAX  = 32,
    parameter int FRAC_W = 16,
    parameter int INT_W  = 4,
    parameter int NW     = $clog2(N_MAX + 1),
    parameter int SUM_W  = INT_W + FRAC_W + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [NW-1:0]           i_n,
    input  logic                    i_mode,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic signed [SUM_W-1:0] o_sum
);
    import harmonic_pkg::*;

    localparam int            AW     = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [NW-1:0] W_NMAX = NW'(N_MAX);

    state_t                  r_state, w_next;
    logic [NW-1:0]           r_n, r_k;
    logic                    r_mode, r_err, r_vld, r_neg;
    logic signed [SUM_W-1:0] r_sum;
    logic [FRAC_W:0]         w_recip;
    logic signed [SUM_W-1:0] w_recip_ext;
    logic [AW-1:0]           w_addr;
    logic                    w_n_ok;

    assign w_n_ok      = (i_n != '0) && (i_n <= W_NMAX);
    assign w_addr      = AW'(r_k - 1'b1);
    assign w_recip_ext = $signed({{INT_W{1'b0}}, w_recip});

    harmonic_recip_rom #(
        .N_MAX  (N_MAX),
        .FRAC_W (FRAC_W),
        .AW     (AW)
    ) u_rom (
        .i_clk  (i_clk),
        .i_addr (w_addr),
        .o_data (w_recip)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = w_n_ok ? ST_RUN : ST_DONE;
            ST_RUN:   if (r_k == r_n) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Valid and sign follow the ROM address by one cycle to line up with its registered output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n    <= '0;
            r_k    <= NW'(1);
            r_mode <= MODE_HARM;
            r_err  <= 1'b0;
            r_vld  <= 1'b0;
            r_neg  <= 1'b0;
            r_sum  <= '0;
        end else begin
            r_vld <= (r_state == ST_RUN);
            r_neg <= (r_mode == MODE_ALT) && !r_k[0];
            if (r_vld)
                r_sum <= r_neg ? (r_sum - w_recip_ext) : (r_sum + w_recip_ext);
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_sum <= '0;
                    r_err <= !w_n_ok;
                    r_k   <= NW'(1);
                    if (w_n_ok) begin
                        r_n    <= i_n;
                        r_mode <= i_mode;
                    end
                end
                ST_RUN: if (r_k != r_n) r_k <= r_k + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done = (r_state == ST_DONE);
    assign o_err  = (r_state == ST_DONE) && r_err;
    assign o_sum  = r_sum;

endmodule

// File: tb/tb_harmonic_series_engine.sv
// Randomized and directed bench for harmonic_series_engine against a plain-arithmetic sum model.
module tb_harmonic_series_engine;

    localparam int N_MAX  = 32;
    localparam int FRAC_W = 16;
    localparam int INT_W  = 4;
    localparam int NW     = $clog2(N_MAX + 1);
    localparam int SUM_W  = INT_W + FRAC_W + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [NW-1:0]           n_in = '0;
    logic                    mode = 1'b0;
    logic                    busy, done, err;
    logic signed [SUM_W-1:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    harmonic_series_engine #(
        .N_MAX (N_MAX), .FRAC_W (FRAC_W), .INT_W (INT_W)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_start (start), .i_n (n_in), .i_mode (mode),
        .o_busy (busy), .o_done (done), .o_err (err), .o_sum (sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_sum(input int n, input bit m);
        longint s = 0;
        for (int k = 1; k <= n; k++) begin
            longint r = (64'sd1 <<< FRAC_W) / k;
            if (m && (k % 2 == 0)) s -= r;
            else                   s += r;
        end
        return s;
    endfunction

    // Drive one run starting at a negedge; returns at the negedge of the cycle after done.
    task automatic run(input int n, input bit m, input bit poke);
        bit     ok = (n >= 1) && (n <= N_MAX);
        longint exp = ok ? ref_sum(n, m) : 0;
        int     busy_cyc = 0, done_cyc = -1, err_at = 0;
        longint sum_at = 0;
        assert (exp < (64'sd1 <<< (INT_W + FRAC_W)) && exp > -(64'sd1 <<< (INT_W + FRAC_W)));
        n_in  = NW'(n);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                n_in  = NW'($urandom_range(0, 40));
                mode  = 1'($urandom);
            end
            if (poke && c == 3) start = 1'b1;
            if (poke && c == 4) start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = c;
                err_at   = int'(err);
                sum_at   = longint'(sum);
                if (poke) start = 1'b1;
                break;
            end
        end
        chk($sformatf("done_cycle n=%0d m=%0d", n, m), done_cyc, ok ? n + 2 : 1);
        chk($sformatf("busy_cycles n=%0d m=%0d", n, m), busy_cyc, ok ? n + 1 : 0);
        chk($sformatf("err n=%0d", n), err_at, ok ? 0 : 1);
        chk($sformatf("sum n=%0d m=%0d", n, m), sum_at, exp);
        @(negedge clk);
        start = 1'b0;
        chk("after_done_idle", {busy, done}, 0);
        chk("sum_held", longint'(sum), exp);
    endtask

    task automatic run_abort(input int n, input int at);
        int dones = 0;
        n_in = NW'(n); mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", longint'(sum), 0);
        for (int c = 0; c < n + 4; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_sum", longint'(sum), 0);
        rst = 1'b0;
        @(negedge clk);

        run(1, 0, 0);
        chk("n1_value", ref_sum(1, 0), 65536);
        run(4, 0, 0);
        run(4, 1, 0);
        run(0, 0, 0);
        run(33, 1, 0);
        run(32, 0, 1);
        run_abort(32, 10);
        run(2, 0, 0);
        run(3, 0, 0);

        for (int i = 0; i < 25; i++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            run($urandom_range(0, 36), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
